// File: rtl/tmr_fault_manager.sv
// -----------------------------------------------------------------------------
// tmr_fault_manager
//
// Purpose:
//   This block reads the registered status from a TMR voter. It filters out
//   short single-core mismatches and confirms a fault only when one core's
//   flag persists. On a confirmed fault it:
//     1. drives a timed reset pulse to the faulty core,
//     2. waits out a hold-off while that core re-synchronises,
//     3. resumes monitoring.
//   A multi-core disagreement, or a new fault on another core while degraded,
//   latches a sticky FATAL state. Only rst leaves FATAL.
//
// Optional feature (macro TMR_FAULT_IRQ_EN):
//   Adds the ports irq / irq_ack. irq is set on entry to RESET_CORE or FATAL.
//   It clears on the edge that samples irq_ack=1. A coincident set wins.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   disagreement     voter status; informational only
//   fault_flags[2:0] per-core mismatch flags: [0]=A [1]=B [2]=C
//   clear_counts     synchronous clear of all event counters (clear wins)
//   core_rst[2:0]    per-core reset request
//   degraded         high in RESET_CORE and RECOVER
//   fatal            sticky no-majority / double-fault indication
//   state[2:0]       0=MONITOR 1=CONFIRM 2=RESET_CORE 3=RECOVER 4=FATAL
//   fault_count_a/b/c  confirmed faults per core, saturating
//   transient_count  flags that cleared (or moved) before confirmation
//   irq / irq_ack    (TMR_FAULT_IRQ_EN only) event interrupt and acknowledge
// -----------------------------------------------------------------------------
module tmr_fault_manager #(
    parameter int PERSIST_CYCLES = 8,
    parameter int RESET_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disagreement,
    input  logic [2:0]       fault_flags,
    input  logic             clear_counts,
`ifdef TMR_FAULT_IRQ_EN
    input  logic             irq_ack,
    output logic             irq,
`endif
    output logic [2:0]       core_rst,
    output logic             degraded,
    output logic             fatal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] fault_count_a,
    output logic [CNT_W-1:0] fault_count_b,
    output logic [CNT_W-1:0] fault_count_c,
    output logic [CNT_W-1:0] transient_count
);

    typedef enum logic [2:0] {
        S_MONITOR    = 3'd0,
        S_CONFIRM    = 3'd1,
        S_RESET_CORE = 3'd2,
        S_RECOVER    = 3'd3,
        S_FATAL      = 3'd4
    } state_t;

    localparam int TMAX = (RESET_CYCLES > HOLDOFF_CYCLES) ? RESET_CYCLES : HOLDOFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(PERSIST_CYCLES + 1);

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [PW-1:0]   r_persist;
    logic [TW-1:0]   r_timer;

    logic            w_single;
    logic            w_multi;
    logic [1:0]      w_new_idx;
    logic [2:0]      w_idx_mask;
    logic            w_match;
    logic            w_other;
    logic            w_confirm;
    logic            w_go_fatal;
    logic            w_unused;

    // disagreement is redundant with fault_flags; decisions use the flags only.
    assign w_unused = disagreement;
    assign state    = r_state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_single   = (fault_flags != 3'd0) && ((fault_flags & (fault_flags - 3'd1)) == 3'd0);
        w_multi    = (fault_flags != 3'd0) && !w_single;
        w_new_idx  = fault_flags[0] ? 2'd0 : (fault_flags[1] ? 2'd1 : 2'd2);
        w_idx_mask = 3'b001 << r_idx;
        w_match    = (fault_flags == w_idx_mask);
        w_other    = |(fault_flags & ~w_idx_mask);
        // Confirm on the edge that samples the PERSIST_CYCLES-th consecutive flag.
        w_confirm  = (r_state == S_CONFIRM) && w_match &&
                     (r_persist == PW'(PERSIST_CYCLES - 1));
        w_go_fatal = (((r_state == S_MONITOR) || (r_state == S_CONFIRM)) && w_multi) ||
                     (((r_state == S_RESET_CORE) || (r_state == S_RECOVER)) && w_other);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_MONITOR;
            r_idx           <= 2'd0;
            r_persist       <= '0;
            r_timer         <= '0;
            core_rst        <= 3'd0;
            degraded        <= 1'b0;
            fatal           <= 1'b0;
            fault_count_a   <= '0;
            fault_count_b   <= '0;
            fault_count_c   <= '0;
            transient_count <= '0;
        end else begin
            if (w_go_fatal) begin
                r_state  <= S_FATAL;
                fatal    <= 1'b1;
                core_rst <= 3'd0;
                degraded <= 1'b0;
            end else begin
                case (r_state)
                    S_MONITOR: begin
                        if (w_single) begin
                            r_state   <= S_CONFIRM;
                            r_idx     <= w_new_idx;
                            r_persist <= PW'(1);
                        end
                    end
                    S_CONFIRM: begin
                        if (w_confirm) begin
                            r_state   <= S_RESET_CORE;
                            r_persist <= '0;
                            core_rst  <= w_idx_mask;
                            degraded  <= 1'b1;
                            r_timer   <= TW'(RESET_CYCLES - 1);
                            case (r_idx)
                                2'd0:    fault_count_a <= sat_inc(fault_count_a);
                                2'd1:    fault_count_b <= sat_inc(fault_count_b);
                                default: fault_count_c <= sat_inc(fault_count_c);
                            endcase
                        end else if (w_match) begin
                            r_persist <= r_persist + 1'b1;
                        end else if (fault_flags == 3'd0) begin
                            r_state         <= S_MONITOR;
                            r_persist       <= '0;
                            transient_count <= sat_inc(transient_count);
                        end else begin
                            // A different single core now disagrees: restart on it.
                            r_idx           <= w_new_idx;
                            r_persist       <= PW'(1);
                            transient_count <= sat_inc(transient_count);
                        end
                    end
                    S_RESET_CORE: begin
                        if (r_timer == '0) begin
                            r_state  <= S_RECOVER;
                            core_rst <= 3'd0;
                            r_timer  <= TW'(HOLDOFF_CYCLES - 1);
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    S_RECOVER: begin
                        if (r_timer == '0) begin
                            r_state  <= S_MONITOR;
                            degraded <= 1'b0;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    S_FATAL: begin
                        fatal    <= 1'b1;
                        core_rst <= 3'd0;
                        degraded <= 1'b0;
                    end
                    default: begin
                        r_state <= S_FATAL;
                        fatal   <= 1'b1;
                    end
                endcase
            end

            // Placed last so it overrides any increment on the same edge.
            if (clear_counts) begin
                fault_count_a   <= '0;
                fault_count_b   <= '0;
                fault_count_c   <= '0;
                transient_count <= '0;
            end
        end
    end

`ifdef TMR_FAULT_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (w_confirm || w_go_fatal) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tmr_fault_manager.sv
module tb_tmr_fault_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        disagreement;
    logic [2:0]  fault_flags;
    logic        clear_counts;

    logic [2:0]  core_rst, s_core_rst;
    logic        degraded, s_degraded;
    logic        fatal, s_fatal;
    logic [2:0]  state, s_state;
    logic [15:0] fault_count_a, fault_count_b, fault_count_c, transient_count;
    logic [1:0]  s_fault_count_a, s_fault_count_b, s_fault_count_c, s_transient_count;
`ifdef TMR_FAULT_IRQ_EN
    logic        irq_ack;
    logic        irq, s_irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign disagreement = |fault_flags;

    tmr_fault_manager u_dut (
        .clk(clk), .rst(rst), .disagreement(disagreement),
        .fault_flags(fault_flags), .clear_counts(clear_counts),
`ifdef TMR_FAULT_IRQ_EN
        .irq_ack(irq_ack), .irq(irq),
`endif
        .core_rst(core_rst), .degraded(degraded), .fatal(fatal), .state(state),
        .fault_count_a(fault_count_a), .fault_count_b(fault_count_b),
        .fault_count_c(fault_count_c), .transient_count(transient_count)
    );

    tmr_fault_manager #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .disagreement(disagreement),
        .fault_flags(fault_flags), .clear_counts(clear_counts),
`ifdef TMR_FAULT_IRQ_EN
        .irq_ack(irq_ack), .irq(s_irq),
`endif
        .core_rst(s_core_rst), .degraded(s_degraded), .fatal(s_fatal), .state(s_state),
        .fault_count_a(s_fault_count_a), .fault_count_b(s_fault_count_b),
        .fault_count_c(s_fault_count_c), .transient_count(s_transient_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        fault_flags = 3'd0;
        clear_counts = 1'b0;
`ifdef TMR_FAULT_IRQ_EN
        irq_ack = 1'b0;
`endif
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({state, core_rst, degraded, fatal} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0", {state, core_rst, degraded, fatal});
        end
        checks++;
        if ({fault_count_a, fault_count_b, fault_count_c, transient_count} !== 64'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0h expected 0",
                     {fault_count_a, fault_count_b, fault_count_c, transient_count});
        end
`ifdef TMR_FAULT_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
`endif
        fault_flags = 3'b010;
        repeat (8) tick;
        fault_flags = 3'b000;
        repeat (3) tick;
        checks++;
        if (core_rst !== 3'b010) begin
            errors++;
            $display("FAIL midreset_pre_core_rst: got %0b expected 010", core_rst);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (core_rst !== 3'b000) begin
            errors++;
            $display("FAIL async_core_rst_drop: got %0b expected 000", core_rst);
        end
        checks++;
        if ({state, degraded, fatal, fault_count_b} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %0h expected 0", {state, degraded, fatal, fault_count_b});
        end
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if ({state, core_rst} !== 6'd0) begin
            errors++;
            $display("FAIL post_release: got %0h expected 0", {state, core_rst});
        end
    endtask

    task automatic test_confirm;
        do_reset;
        fault_flags = 3'b010;
        for (int i = 1; i <= 7; i++) begin
            tick;
            checks++;
            if (state !== 3'd1) begin
                errors++;
                $display("FAIL confirm_wait[%0d]: got state %0d expected 1", i, state);
            end
        end
        tick;
        checks++;
        if ({state, core_rst, degraded} !== {3'd2, 3'b010, 1'b1}) begin
            errors++;
            $display("FAIL confirm_edge: got state %0d core_rst %0b degraded %0b expected 2 010 1",
                     state, core_rst, degraded);
        end
        checks++;
        if (fault_count_b !== 16'd1 || fault_count_a !== 16'd0 || fault_count_c !== 16'd0) begin
            errors++;
            $display("FAIL confirm_count: got a %0d b %0d c %0d expected 0 1 0",
                     fault_count_a, fault_count_b, fault_count_c);
        end
`ifdef TMR_FAULT_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_confirm: got %0b expected 1", irq); end
`endif
        fault_flags = 3'b000;
        for (int i = 1; i <= 15; i++) begin
`ifdef TMR_FAULT_IRQ_EN
            irq_ack = (i == 5);
`endif
            tick;
            checks++;
            if (state !== 3'd2 || core_rst !== 3'b010) begin
                errors++;
                $display("FAIL core_rst_hold[%0d]: got state %0d core_rst %0b expected 2 010", i, state, core_rst);
            end
`ifdef TMR_FAULT_IRQ_EN
            checks++;
            if (irq !== (i < 5)) begin
                errors++;
                $display("FAIL irq_ack_clear[%0d]: got %0b expected %0b", i, irq, (i < 5));
            end
`endif
        end
`ifdef TMR_FAULT_IRQ_EN
        irq_ack = 1'b0;
`endif
        tick;
        checks++;
        if ({state, core_rst, degraded} !== {3'd3, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL enter_recover: got state %0d core_rst %0b degraded %0b expected 3 000 1",
                     state, core_rst, degraded);
        end
        for (int i = 1; i <= 63; i++) begin
            tick;
            checks++;
            if (state !== 3'd3) begin
                errors++;
                $display("FAIL recover_hold[%0d]: got state %0d expected 3", i, state);
            end
        end
        tick;
        checks++;
        if ({state, degraded, fatal} !== 5'd0) begin
            errors++;
            $display("FAIL back_to_monitor: got state %0d degraded %0b fatal %0b expected 0 0 0",
                     state, degraded, fatal);
        end
    endtask

    task automatic test_transient;
        do_reset;
        fault_flags = 3'b001;
        for (int i = 1; i <= 5; i++) begin
            tick;
            checks++;
            if (state !== 3'd1 || core_rst !== 3'd0) begin
                errors++;
                $display("FAIL transient_confirm[%0d]: got state %0d core_rst %0b expected 1 000", i, state, core_rst);
            end
        end
        fault_flags = 3'b000;
        tick;
        checks++;
        if (state !== 3'd0 || transient_count !== 16'd1 || fault_count_a !== 16'd0 || core_rst !== 3'd0) begin
            errors++;
            $display("FAIL transient_end: got state %0d trans %0d fa %0d core_rst %0b expected 0 1 0 000",
                     state, transient_count, fault_count_a, core_rst);
        end
    endtask

    task automatic test_switch;
        do_reset;
        fault_flags = 3'b001;
        repeat (2) tick;
        fault_flags = 3'b100;
        tick;
        checks++;
        if (state !== 3'd1 || transient_count !== 16'd1) begin
            errors++;
            $display("FAIL switch_restart: got state %0d trans %0d expected 1 1", state, transient_count);
        end
        for (int i = 1; i <= 6; i++) begin
            tick;
            checks++;
            if (state !== 3'd1) begin
                errors++;
                $display("FAIL switch_wait[%0d]: got state %0d expected 1", i, state);
            end
        end
        tick;
        checks++;
        if (state !== 3'd2 || core_rst !== 3'b100 || fault_count_c !== 16'd1 || fault_count_a !== 16'd0) begin
            errors++;
            $display("FAIL switch_confirm: got state %0d core_rst %0b fc %0d fa %0d expected 2 100 1 0",
                     state, core_rst, fault_count_c, fault_count_a);
        end
    endtask

    task automatic test_fatal_monitor;
        do_reset;
`ifdef TMR_FAULT_IRQ_EN
        irq_ack = 1'b1;
`endif
        fault_flags = 3'b011;
        tick;
        checks++;
        if ({state, fatal, degraded, core_rst} !== {3'd4, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL multi_fatal: got state %0d fatal %0b degraded %0b core_rst %0b expected 4 1 0 000",
                     state, fatal, degraded, core_rst);
        end
`ifdef TMR_FAULT_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %0b expected 1", irq); end
        irq_ack = 1'b0;
`endif
        fault_flags = 3'b000;
        repeat (10) tick;
        checks++;
        if (state !== 3'd4 || fatal !== 1'b1) begin
            errors++;
            $display("FAIL fatal_sticky: got state %0d fatal %0b expected 4 1", state, fatal);
        end
        do_reset;
        checks++;
        if (state !== 3'd0 || fatal !== 1'b0) begin
            errors++;
            $display("FAIL fatal_exit_rst: got state %0d fatal %0b expected 0 0", state, fatal);
        end
    endtask

    task automatic test_recover_fault;
        do_reset;
        fault_flags = 3'b010;
        repeat (8) tick;
        fault_flags = 3'b000;
        repeat (16) tick;
        repeat (10) tick;
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL recover_pre: got state %0d expected 3", state);
        end
        fault_flags = 3'b100;
        tick;
        checks++;
        if ({state, fatal, degraded, core_rst} !== {3'd4, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL recover_double_fault: got state %0d fatal %0b degraded %0b core_rst %0b expected 4 1 0 000",
                     state, fatal, degraded, core_rst);
        end
    endtask

    task automatic test_recover_ignore;
        do_reset;
        fault_flags = 3'b010;
        repeat (8) tick;
        fault_flags = 3'b000;
        repeat (16) tick;
        fault_flags = 3'b010;
        for (int i = 1; i <= 60; i++) begin
            tick;
            checks++;
            if (state !== 3'd3 || fatal !== 1'b0) begin
                errors++;
                $display("FAIL recover_ignore[%0d]: got state %0d fatal %0b expected 3 0", i, state, fatal);
            end
        end
        fault_flags = 3'b000;
        repeat (3) tick;
        tick;
        checks++;
        if (state !== 3'd0 || degraded !== 1'b0 || fatal !== 1'b0) begin
            errors++;
            $display("FAIL recover_ignore_exit: got state %0d degraded %0b fatal %0b expected 0 0 0",
                     state, degraded, fatal);
        end
    endtask

    task automatic test_reset_core_fault;
        do_reset;
        fault_flags = 3'b100;
        repeat (8) tick;
        fault_flags = 3'b000;
        repeat (4) tick;
        checks++;
        if (core_rst !== 3'b100 || state !== 3'd2) begin
            errors++;
            $display("FAIL rc_pre: got state %0d core_rst %0b expected 2 100", state, core_rst);
        end
        fault_flags = 3'b001;
        tick;
        checks++;
        if ({state, fatal, degraded, core_rst} !== {3'd4, 1'b1, 1'b0, 3'd0} || fault_count_c !== 16'd1) begin
            errors++;
            $display("FAIL rc_fault_fatal: got state %0d fatal %0b core_rst %0b fc %0d expected 4 1 000 1",
                     state, fatal, core_rst, fault_count_c);
        end
    endtask

    task automatic test_saturate;
        do_reset;
        for (int k = 1; k <= 4; k++) begin
            fault_flags = 3'b001;
            repeat (8) tick;
            checks++;
            if (state !== 3'd2 || s_state !== 3'd2) begin
                errors++;
                $display("FAIL sat_confirm[%0d]: got state %0d/%0d expected 2", k, state, s_state);
            end
`ifdef TMR_FAULT_IRQ_EN
            checks++;
            if (irq !== 1'b1 || s_irq !== 1'b1) begin
                errors++;
                $display("FAIL sat_irq_set[%0d]: got %0b/%0b expected 1", k, irq, s_irq);
            end
            irq_ack = 1'b1;
`endif
            fault_flags = 3'b000;
            tick;
`ifdef TMR_FAULT_IRQ_EN
            checks++;
            if (irq !== 1'b0 || s_irq !== 1'b0) begin
                errors++;
                $display("FAIL sat_irq_ack[%0d]: got %0b/%0b expected 0", k, irq, s_irq);
            end
            irq_ack = 1'b0;
`endif
            repeat (79) tick;
            checks++;
            if (state !== 3'd0) begin
                errors++;
                $display("FAIL sat_monitor[%0d]: got state %0d expected 0", k, state);
            end
        end
        checks++;
        if (s_fault_count_a !== 2'd3) begin
            errors++;
            $display("FAIL sat_count: got %0d expected 3", s_fault_count_a);
        end
        checks++;
        if (fault_count_a !== 16'd4) begin
            errors++;
            $display("FAIL wide_count: got %0d expected 4", fault_count_a);
        end
        fault_flags = 3'b001;
        repeat (7) tick;
        clear_counts = 1'b1;
        tick;
        clear_counts = 1'b0;
        checks++;
        if (s_fault_count_a !== 2'd0 || fault_count_a !== 16'd0) begin
            errors++;
            $display("FAIL clear_wins: got %0d/%0d expected 0", s_fault_count_a, fault_count_a);
        end
        checks++;
        if (state !== 3'd2 || core_rst !== 3'b001) begin
            errors++;
            $display("FAIL clear_no_fsm_effect: got state %0d core_rst %0b expected 2 001", state, core_rst);
        end
        fault_flags = 3'b000;
    endtask

    initial begin
        rst = 1'b1;
        fault_flags = 3'd0;
        clear_counts = 1'b0;
`ifdef TMR_FAULT_IRQ_EN
        irq_ack = 1'b0;
`endif
        test_reset;
        test_confirm;
        test_transient;
        test_switch;
        test_fatal_monitor;
        test_recover_fault;
        test_recover_ignore;
        test_reset_core_fault;
        test_saturate;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmr_fault_manager.md
Name: tmr_fault_manager

Overview:
Consumer of the registered TMR voter status (disagreement, fault_flags). It filters transient mismatches and confirms persistent single-core faults. On a confirmed fault it issues a timed reset pulse to the faulty core, holds off while that core re-synchronises, then resumes monitoring. A multi-core disagreement, or a second fault while degraded, latches a sticky fatal state.

Parameters:
PERSIST_CYCLES, 8, consecutive sampled cycles a single-core flag must hold before a fault is confirmed; legal range is 2 or more.
RESET_CYCLES, 16, number of cycles core_rst[i] is held high.
HOLDOFF_CYCLES, 64, number of recovery cycles after core reset release, with monitoring suspended.
CNT_W, 16, width of the saturating counters.

Ports:
clk  in  1  single system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
disagreement  in  1  voter status; informational, fault_flags drives all decisions.
fault_flags  in  3  [0]=A, [1]=B, [2]=C differs from majority.
clear_counts  in  1  synchronous clear of all counters.
core_rst  out  3  active-high reset request per core.
degraded  out  1  high in RESET_CORE and RECOVER.
fatal  out  1  sticky no-majority / double-fault indication.
state  out  3  0=MONITOR, 1=CONFIRM, 2=RESET_CORE, 3=RECOVER, 4=FATAL.
fault_count_a / fault_count_b / fault_count_c  out  CNT_W each  confirmed faults per core, saturating.
transient_count  out  CNT_W  flags that cleared before confirmation, saturating.

Behaviour:
- Reset: every output is 0; state=MONITOR; internal persist, timer and index registers are 0. Asserting rst in any state aborts it immediately, and core_rst drops asynchronously.
- All outputs are registered. fault_flags is sampled on each rising edge.
- MONITOR, flags with one bit set: go to CONFIRM; latch idx; persist=1.
- MONITOR, flags with two or more bits set: go to FATAL.
- MONITOR, flags==0: stay in MONITOR.
- CONFIRM, flags==onehot(idx): persist++. When persist reaches PERSIST_CYCLES, go to RESET_CORE and increment fault_count[idx] on the same edge. The fault is therefore confirmed on the edge that samples the PERSIST_CYCLES-th consecutive high flag.
- CONFIRM, flags==0: go to MONITOR; transient_count++.
- CONFIRM, a different single bit set: restart CONFIRM with the new idx, persist=1, and increment transient_count.
- CONFIRM, two or more bits set: go to FATAL.
- RESET_CORE: core_rst=onehot(idx) for exactly RESET_CYCLES cycles, starting on the entry edge. Then go to RECOVER with core_rst=0.
- RECOVER: lasts HOLDOFF_CYCLES cycles, then go to MONITOR. Flag bit idx is ignored in this state.
- RESET_CORE or RECOVER, any flag bit other than idx set: go to FATAL on that edge. core_rst clears on that same edge.
- FATAL: fatal=1, core_rst=0, degraded=0. The only exit is rst.
- Counters saturate at 2^CNT_W-1.
- clear_counts zeroes all four counters. If clear_counts coincides with an increment, the clear wins. clear_counts has no effect on the FSM.

Optional Feature:
Macro TMR_FAULT_IRQ_EN.
- When defined, adds two ports: irq (out, 1) and irq_ack (in, 1).
- irq is set on the edge entering RESET_CORE or FATAL. It stays high until sampled irq_ack=1, then clears on the next edge.
- If a new set event coincides with irq_ack, the set wins.
- irq resets to 0.
- When undefined, neither port exists and the behaviour above is unchanged.

Test Plan:
1. Assert rst mid-RESET_CORE with core_rst=3'b010 -> core_rst=0 immediately; all outputs 0; state=0 after release.
2. Defaults, fault_flags=3'b010 held for 8 cycles -> on the 8th sampling edge: state=2, fault_count_b=1, core_rst=3'b010 for 16 cycles, degraded=1. Then state=3 for 64 cycles, then state=0 with degraded=0.
3. fault_flags=3'b001 for 5 cycles, then 0 -> state 1 then 0; transient_count=1; core_rst never asserted; fault_count_a=0.
4. fault_flags=3'b011 while in MONITOR -> next edge state=4, fatal=1. It stays there after flags return to 0, until rst.
5. During RECOVER for core B (idx=1), fault_flags=3'b100 -> state=4, fatal=1, degraded=0. In a separate run, fault_flags=3'b010 during RECOVER -> ignored, returns to MONITOR.
6. CNT_W=2, four confirmed faults on A -> fault_count_a saturates at 3. Then clear_counts on the confirm edge of a fifth fault -> fault_count_a=0. With TMR_FAULT_IRQ_EN: irq rises on each RESET_CORE entry and clears one edge after irq_ack.
